// File: rtl/instr_stream_seq.sv
// instr_stream_seq: loadable program memory issuing one word per cycle with stall, redirect and loop modes
module instr_stream_seq #(
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 16,
   parameter int                ADDR_W   = 4,
   parameter logic [DATA_W-1:0] NOP_WORD = '0,
   parameter bit                LOOP_EN  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              start,
   input  logic              stall,
   input  logic              redirect_en,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [DATA_W-1:0] Instruction,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [15:0]       issued_cnt,
   output logic              busy,
   output logic              done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0] len, plen;
   logic fin, last, over;
   assign plen = (prog_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : prog_len;
   assign last = {1'b0, pc} == len - (ADDR_W+1)'(1);
   assign over = {1'b0, redirect_addr} >= len;
   assign busy = state == RUN;
   assign done = state == DONE;
   always_ff @(posedge clk)
      if (!reset && load_en && state != RUN) mem[load_addr] <= load_data;
   // fin marks the cycle where the final word is still on Instruction before DONE
   always_ff @(posedge clk)
      if (reset) begin
         state       <= IDLE;
         Instruction <= NOP_WORD;
         instr_valid <= 1'b0;
         pc          <= '0;
         issued_cnt  <= '0;
         len         <= '0;
         fin         <= 1'b0;
      end else if (state != RUN) begin
         if (start) begin
            len         <= plen;
            pc          <= '0;
            issued_cnt  <= '0;
            Instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            fin         <= 1'b0;
            state       <= (plen == '0) ? DONE : RUN;
         end
      end else if (redirect_en) begin
         Instruction <= NOP_WORD;
         instr_valid <= 1'b0;
         fin         <= 1'b0;
         pc          <= (over && LOOP_EN) ? '0 : redirect_addr;
         if (over && !LOOP_EN) state <= DONE;
      end else if (!stall) begin
         if (fin) begin
            state       <= DONE;
            Instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            fin         <= 1'b0;
         end else begin
            Instruction <= mem[pc];
            instr_valid <= 1'b1;
            issued_cnt  <= issued_cnt + 16'(issued_cnt != 16'hFFFF);
            pc          <= (last && LOOP_EN) ? '0 : pc + ADDR_W'(1);
            fin         <= last && !LOOP_EN;
         end
      end
endmodule

// File: tb/tb_instr_stream_seq.sv
// tb_instr_stream_seq: one-shot and looping sequencers checked against a cycle reference model
module tb_instr_stream_seq;
   localparam logic [31:0] ADD = 32'h00E91020, LW = 32'h8CE50006, SW = 32'hACA20004, BEQ = 32'h104A1822;
   logic clk = 0, reset = 1, load_en = 0, start = 0, stall = 0, redirect_en = 0;
   logic [3:0] load_addr = 0, redirect_addr = 0;
   logic [31:0] load_data = 0;
   logic [4:0] prog_len = 0;
   logic [31:0] ins [2];
   logic val [2], busy [2], done [2];
   logic [3:0] pcs [2];
   logic [15:0] cnt [2];
   int checks = 0, errors = 0;
   logic [31:0] mm [2][16];
   logic [31:0] mi [2];
   bit mv [2], fin [2];
   int st [2], mpc [2], len [2], mcnt [2];
   logic [31:0] prog [4];
   always #5 clk = ~clk;
   instr_stream_seq #(.LOOP_EN(1'b0)) d0 (.clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .prog_len(prog_len), .start(start), .stall(stall), .redirect_en(redirect_en),
      .redirect_addr(redirect_addr), .Instruction(ins[0]), .instr_valid(val[0]), .pc(pcs[0]),
      .issued_cnt(cnt[0]), .busy(busy[0]), .done(done[0]));
   instr_stream_seq #(.LOOP_EN(1'b1)) d1 (.clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .prog_len(prog_len), .start(start), .stall(stall), .redirect_en(redirect_en),
      .redirect_addr(redirect_addr), .Instruction(ins[1]), .instr_valid(val[1]), .pc(pcs[1]),
      .issued_cnt(cnt[1]), .busy(busy[1]), .done(done[1]));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // st: 0 idle, 1 run, 2 done; model index 1 is the looping instance
   task automatic model;
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            st[m] = 0; mi[m] = 0; mv[m] = 0; mpc[m] = 0; mcnt[m] = 0; len[m] = 0; fin[m] = 0;
         end else if (st[m] != 1) begin
            if (load_en) mm[m][load_addr] = load_data;
            if (start) begin
               len[m] = (prog_len > 16) ? 16 : int'(prog_len);
               mpc[m] = 0; mcnt[m] = 0; mi[m] = 0; mv[m] = 0; fin[m] = 0;
               st[m] = (len[m] > 0) ? 1 : 2;
            end
         end else if (redirect_en) begin
            mi[m] = 0; mv[m] = 0; fin[m] = 0;
            if (int'(redirect_addr) < len[m]) mpc[m] = int'(redirect_addr);
            else if (m == 1) mpc[m] = 0;
            else begin
               mpc[m] = int'(redirect_addr);
               st[m] = 2;
            end
         end else if (!stall) begin
            if (fin[m]) begin
               st[m] = 2; mi[m] = 0; mv[m] = 0; fin[m] = 0;
            end else begin
               mi[m] = mm[m][mpc[m]];
               mv[m] = 1;
               if (mcnt[m] < 65535) mcnt[m]++;
               if (mpc[m] == len[m] - 1 && m == 1) mpc[m] = 0;
               else begin
                  fin[m] = (mpc[m] == len[m] - 1);
                  mpc[m] = (mpc[m] + 1) % 16;
               end
            end
         end
      end
   endtask
   task automatic step;
      @(posedge clk);
      model;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("d%0d_instr", m), ins[m], mi[m]);
         chk($sformatf("d%0d_valid", m), val[m], mv[m]);
         chk($sformatf("d%0d_pc", m), pcs[m], mpc[m]);
         chk($sformatf("d%0d_cnt", m), cnt[m], mcnt[m]);
         chk($sformatf("d%0d_busy", m), busy[m], st[m] == 1);
         chk($sformatf("d%0d_done", m), done[m], st[m] == 2);
      end
   endtask
   initial begin
      prog = '{ADD, LW, SW, BEQ};
      step;
      chk("rst_instr", ins[0], 32'h0);
      chk("rst_valid", val[0], 0);
      chk("rst_pc", pcs[0], 0);
      chk("rst_busy", busy[0], 0);
      chk("rst_done", done[0], 0);
      reset = 0;
      for (int i = 0; i < 16; i++) begin
         load_en = 1; load_addr = 4'(i); load_data = (i < 4) ? prog[i] : $urandom;
         step;
      end
      load_en = 0;
      prog_len = 2; start = 1; step; start = 0;
      for (int i = 0; i < 8; i++) begin
         step;
         chk("loop_instr", ins[1], prog[i % 2]);
         chk("loop_busy", busy[1], 1);
         chk("loop_done", done[1], 0);
      end
      prog_len = 4; start = 1; step; start = 0;
      chk("start_valid", val[0], 0);
      for (int i = 0; i < 4; i++) begin
         step;
         chk("seq_instr", ins[0], prog[i]);
         chk("seq_valid", val[0], 1);
      end
      step;
      chk("seq_done", done[0], 1);
      chk("seq_nop", ins[0], 32'h0);
      chk("seq_cnt", cnt[0], 4);
      start = 1; step; start = 0;
      step; step;
      chk("stall_lw0", ins[0], LW);
      stall = 1;
      step; chk("stall_lw1", ins[0], LW);
      step; chk("stall_lw2", ins[0], LW);
      stall = 0;
      step; chk("stall_sw", ins[0], SW);
      step; chk("stall_beq", ins[0], BEQ);
      step;
      chk("stall_done", done[0], 1);
      chk("stall_cnt", cnt[0], 4);
      start = 1; step; start = 0;
      step; step; step;
      chk("redir_sw", ins[0], SW);
      redirect_en = 1; redirect_addr = 0;
      step;
      chk("redir_bubble", val[0], 0);
      chk("redir_pc", pcs[0], 0);
      redirect_en = 0;
      step;
      chk("redir_add", ins[0], ADD);
      chk("redir_pc1", pcs[0], 1);
      repeat (4) step;
      chk("redir_done", done[0], 1);
      chk("redir_cnt", cnt[0], 7);
      prog_len = 0; start = 1; step; start = 0;
      chk("len0_done", done[0], 1);
      chk("len0_valid", val[0], 0);
      prog_len = 4; start = 1; step; start = 0;
      load_en = 1; load_addr = 1; load_data = 32'hDEADBEEF;
      step;
      load_en = 0;
      step;
      chk("runload_lw", ins[0], LW);
      reset = 1; step;
      for (int m = 0; m < 2; m++) begin
         chk("midrst_instr", ins[m], 32'h0);
         chk("midrst_valid", val[m], 0);
         chk("midrst_pc", pcs[m], 0);
         chk("midrst_busy", busy[m], 0);
      end
      reset = 0;
      prog_len = 4; start = 1; step; start = 0;
      for (int i = 0; i < 4; i++) begin
         step;
         chk("restart_d0", ins[0], prog[i]);
         chk("restart_d1", ins[1], prog[i]);
      end
      step;
      chk("restart_done", done[0], 1);
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom % 64) == 0;
         load_en = ($urandom % 4) == 0;
         load_addr = 4'($urandom);
         load_data = $urandom;
         start = ($urandom % 8) == 0;
         prog_len = 5'($urandom);
         stall = ($urandom % 4) == 0;
         redirect_en = ($urandom % 10) == 0;
         redirect_addr = 4'($urandom);
         step;
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
